// File: rtl/corr_pkg.sv
// Shared FSM state encoding and mode constants for the window correlation scorer.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } corr_state_e;

  typedef enum logic {
    MODE_SIM = 1'b0,
    MODE_SAD = 1'b1
  } corr_mode_e;

endpackage

// File: rtl/window_corr_score_if.sv
// Bus bundle for window_corr_score; best-score tracker signals exist only with CORR_BEST_TRACK_EN.
interface window_corr_score_if #(
  parameter int PIX_W   = 10,
  parameter int COORD_W = 13,
  parameter int SCORE_W = 32
);
  logic               iStart;
  logic               iAbort;
  logic               iMode;
  logic [COORD_W-1:0] iXstart;
  logic [COORD_W-1:0] iYstart;
  logic [PIX_W-1:0]   iSram_pix;
  logic [PIX_W-1:0]   iSearch_pix;
  logic [COORD_W-1:0] oX_sram;
  logic [COORD_W-1:0] oY_sram;
  logic [COORD_W-1:0] oX_search;
  logic [COORD_W-1:0] oY_search;
  logic               oAddr_valid;
  logic               oBusy;
  logic               oDone;
  logic [SCORE_W-1:0] oScore;
`ifdef CORR_BEST_TRACK_EN
  logic               iClr_best;
  logic [SCORE_W-1:0] oBest_score;
  logic [COORD_W-1:0] oBest_X;
  logic [COORD_W-1:0] oBest_Y;
`endif

  modport slave (
    input  iStart, iAbort, iMode, iXstart, iYstart, iSram_pix, iSearch_pix,
`ifdef CORR_BEST_TRACK_EN
    input  iClr_best,
    output oBest_score, oBest_X, oBest_Y,
`endif
    output oX_sram, oY_sram, oX_search, oY_search, oAddr_valid, oBusy, oDone, oScore
  );

  modport master (
    output iStart, iAbort, iMode, iXstart, iYstart, iSram_pix, iSearch_pix,
`ifdef CORR_BEST_TRACK_EN
    output iClr_best,
    input  oBest_score, oBest_X, oBest_Y,
`endif
    input  oX_sram, oY_sram, oX_search, oY_search, oAddr_valid, oBusy, oDone, oScore
  );
endinterface

// File: rtl/corr_pix_term.sv
// Registered per-pixel term: |a-b| in SAD mode, (2^PIX_W-1)-|a-b| in similarity mode.
module corr_pix_term
  import corr_pkg::*;
#(
  parameter int PIX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic             in_last,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  corr_mode_e       mode,
  output logic [PIX_W-1:0] term,
  output logic             term_vld,
  output logic             term_last
);
  logic [PIX_W-1:0] diff;
  logic [PIX_W-1:0] term_nxt;

  always_comb begin
    diff     = (a >= b) ? (a - b) : (b - a);
    term_nxt = (mode == MODE_SAD) ? diff : ('1 - diff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term      <= '0;
      term_vld  <= 1'b0;
      term_last <= 1'b0;
    end else if (flush) begin
      term_vld  <= 1'b0;
      term_last <= 1'b0;
    end else begin
      term_vld  <= in_vld;
      term_last <= in_vld & in_last;
      if (in_vld) term <= term_nxt;
    end
  end
endmodule

// File: rtl/window_corr_score.sv
// Window correlation scorer: raster-scans a WIN_W x WIN_H window and accumulates a
// similarity or SAD score. Optional best-run tracker enabled by CORR_BEST_TRACK_EN.
module window_corr_score #(
  parameter int PIX_W   = 10,
  parameter int WIN_W   = 64,
  parameter int WIN_H   = 48,
  parameter int COORD_W = 13,
  parameter int SCORE_W = 32,
  parameter int RD_LAT  = 2
) (
  input logic                iCLK,
  input logic                iRST_N,
  window_corr_score_if.slave bus
);
  import corr_pkg::*;

  localparam int unsigned N = WIN_W * WIN_H;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIN_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(WIN_H - 1);

  if (SCORE_W < PIX_W + $clog2(N) || RD_LAT < 1 || WIN_W < 1 || WIN_H < 1) begin : g_param_check
    $error("window_corr_score: illegal parameters (SCORE_W too narrow or zero-sized window/latency)");
  end

  corr_state_e        state, state_nxt;
  corr_mode_e         mode;
  logic [COORD_W-1:0] x_off, y_off, x_org, y_org;
  logic               addr_valid, addr_last, flush;
  logic [RD_LAT-1:0]  rd_vld, rd_last;
  logic [PIX_W-1:0]   term;
  logic               term_vld, term_last;
  logic [SCORE_W-1:0] acc, score;
  logic               acc_last;

  always_comb begin
    addr_valid = (state == ADDR);
    addr_last  = (x_off == X_LAST) && (y_off == Y_LAST);
    flush      = (state == IDLE);
    state_nxt  = state;
    unique case (state)
      IDLE:    if (bus.iStart && !bus.iAbort) state_nxt = ADDR;
      ADDR:    if (bus.iAbort) state_nxt = IDLE;
               else if (addr_last) state_nxt = DRAIN;
      DRAIN:   if (bus.iAbort) state_nxt = IDLE;
               else if (acc_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_off <= '0;
      y_off <= '0;
      x_org <= '0;
      y_org <= '0;
      mode  <= MODE_SIM;
    end else if (state == IDLE) begin
      if (state_nxt == ADDR) begin
        x_off <= '0;
        y_off <= '0;
        x_org <= bus.iXstart;
        y_org <= bus.iYstart;
        mode  <= corr_mode_e'(bus.iMode);
      end
    end else if (state == ADDR) begin
      if (x_off == X_LAST) begin
        x_off <= '0;
        y_off <= y_off + COORD_W'(1);
      end else begin
        x_off <= x_off + COORD_W'(1);
      end
    end
  end

  // Valid/last tags ride alongside the SRAM read latency; IDLE flushes anything left by an abort.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_vld  <= '0;
      rd_last <= '0;
    end else if (flush) begin
      rd_vld  <= '0;
      rd_last <= '0;
    end else begin
      rd_vld  <= (rd_vld << 1) | RD_LAT'(addr_valid);
      rd_last <= (rd_last << 1) | RD_LAT'(addr_valid & addr_last);
    end
  end

  corr_pix_term #(.PIX_W(PIX_W)) u_pix_term (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .flush     (flush),
    .in_vld    (rd_vld[RD_LAT-1]),
    .in_last   (rd_last[RD_LAT-1]),
    .a         (bus.iSram_pix),
    .b         (bus.iSearch_pix),
    .mode      (mode),
    .term      (term),
    .term_vld  (term_vld),
    .term_last (term_last)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc      <= '0;
      acc_last <= 1'b0;
      score    <= '0;
    end else begin
      if (flush) begin
        acc      <= '0;
        acc_last <= 1'b0;
      end else begin
        if (term_vld) acc <= acc + SCORE_W'(term);
        acc_last <= term_vld & term_last;
      end
      if (state == DRAIN && state_nxt == DONE) score <= acc;
    end
  end

  assign bus.oX_sram     = x_org + x_off;
  assign bus.oY_sram     = y_org + y_off;
  assign bus.oX_search   = x_off;
  assign bus.oY_search   = y_off;
  assign bus.oAddr_valid = addr_valid;
  assign bus.oBusy       = (state != IDLE);
  assign bus.oDone       = (state == DONE);
  assign bus.oScore      = score;

`ifdef CORR_BEST_TRACK_EN
  logic               best_vld, better;
  logic [SCORE_W-1:0] best_score;
  logic [COORD_W-1:0] best_x, best_y;

  always_comb better = (mode == MODE_SIM) ? (score > best_score) : (score < best_score);

  // Tracker samples during the oDone cycle so a coinciding clear still keeps the new run.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      best_vld   <= 1'b0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end else if (state == DONE) begin
      if (bus.iClr_best || !best_vld || better) begin
        best_vld   <= 1'b1;
        best_score <= score;
        best_x     <= x_org;
        best_y     <= y_org;
      end
    end else if (bus.iClr_best) begin
      best_vld   <= 1'b0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end
  end

  assign bus.oBest_score = best_score;
  assign bus.oBest_X     = best_x;
  assign bus.oBest_Y     = best_y;
`endif
endmodule
